// File: rtl/dual_issue_stage_if.sv
// Issue-stage bundle: decoded pair from decode, accept/stall handshake, and both routed slots.
interface dual_issue_stage_if #(
  parameter int REG_ADDR_W = 7,
  parameter int PAYLOAD_W  = 64
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_ready;

  logic [REG_ADDR_W-1:0] i1_ra, i1_rb, i1_rc, i1_rt;
  logic                  i1_useA, i1_useB, i1_useC, i1_we, i1_pipe, i1_memRead;
  logic [PAYLOAD_W-1:0]  i1_payload;

  logic                  i2_valid;
  logic [REG_ADDR_W-1:0] i2_ra, i2_rb, i2_rc, i2_rt;
  logic                  i2_useA, i2_useB, i2_useC, i2_we, i2_pipe, i2_memRead;
  logic [PAYLOAD_W-1:0]  i2_payload;

  logic                  s1_valid, s2_valid;
  logic [REG_ADDR_W-1:0] s1_ra, s1_rb, s1_rc, s1_rt;
  logic [REG_ADDR_W-1:0] s2_ra, s2_rb, s2_rc, s2_rt;
  logic                  s1_we, s1_memRead, s2_we, s2_memRead;
  logic [PAYLOAD_W-1:0]  s1_payload, s2_payload;

  modport slave (
    input  flush, in_valid, out_ready,
    input  i1_ra, i1_rb, i1_rc, i1_rt, i1_useA, i1_useB, i1_useC, i1_we, i1_pipe, i1_memRead,
    input  i1_payload,
    input  i2_valid,
    input  i2_ra, i2_rb, i2_rc, i2_rt, i2_useA, i2_useB, i2_useC, i2_we, i2_pipe, i2_memRead,
    input  i2_payload,
    output in_ready,
    output s1_valid, s1_ra, s1_rb, s1_rc, s1_rt, s1_we, s1_memRead, s1_payload,
    output s2_valid, s2_ra, s2_rb, s2_rc, s2_rt, s2_we, s2_memRead, s2_payload
  );

  modport master (
    output flush, in_valid, out_ready,
    output i1_ra, i1_rb, i1_rc, i1_rt, i1_useA, i1_useB, i1_useC, i1_we, i1_pipe, i1_memRead,
    output i1_payload,
    output i2_valid,
    output i2_ra, i2_rb, i2_rc, i2_rt, i2_useA, i2_useB, i2_useC, i2_we, i2_pipe, i2_memRead,
    output i2_payload,
    input  in_ready,
    input  s1_valid, s1_ra, s1_rb, s1_rc, s1_rt, s1_we, s1_memRead, s1_payload,
    input  s2_valid, s2_ra, s2_rb, s2_rc, s2_rt, s2_we, s2_memRead, s2_payload
  );
endinterface

// File: rtl/dual_issue_stage.sv
// Dual-issue stage: pipe routing, pair split on conflicts, load-use bubbles ahead of REG/EX.
// Optional performance counters are built when ISSUE_PERF_CNT_EN is defined.
module dual_issue_stage #(
  parameter int REG_ADDR_W       = 7,
  parameter int PAYLOAD_W        = 64,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  dual_issue_stage_if.slave  bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_dual,
  output logic [31:0]        perf_split,
  output logic [31:0]        perf_bubble
`endif
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] ra, rb, rc, rt;
    logic                  use_a, use_b, use_c, we, pipe, mem_read;
    logic [PAYLOAD_W-1:0]  payload;
  } instr_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] ra, rb, rc, rt;
    logic                  we, mem_read;
    logic [PAYLOAD_W-1:0]  payload;
  } slot_t;

  typedef enum logic {EMPTY, HOLD} state_t;

  localparam logic [1:0] BUBBLES = 2'(LOAD_USE_BUBBLES);

  function automatic logic reads(input instr_t i, input logic [REG_ADDR_W-1:0] r);
    reads = (i.use_a & (i.ra == r)) | (i.use_b & (i.rb == r)) | (i.use_c & (i.rc == r));
  endfunction

  // a is older in program order than b
  function automatic logic conflict(input instr_t a, input instr_t b);
    conflict = (a.pipe == b.pipe) | (a.we & reads(b, a.rt)) | (a.we & b.we & (a.rt == b.rt));
  endfunction

  function automatic logic load_dep(input instr_t i, input slot_t a, input slot_t b);
    load_dep = (a.valid & a.we & a.mem_read & reads(i, a.rt)) |
               (b.valid & b.we & b.mem_read & reads(i, b.rt));
  endfunction

  function automatic slot_t to_slot(input instr_t i);
    to_slot = '{valid: 1'b1, ra: i.ra, rb: i.rb, rc: i.rc, rt: i.rt,
                we: i.we, mem_read: i.mem_read, payload: i.payload};
  endfunction

  state_t     state;
  logic [1:0] bubble_cnt;
  instr_t     hold_q, pend1_q, pend2_q;
  logic       pend2_v_q;
  slot_t      s1_q, s2_q;

  instr_t in1, in2, src1, src2;
  logic   src2_v, accept, fresh, drain, pair_conf, hazard, do_issue;
  slot_t  s1_d, s2_d;

  assign in1 = '{ra: bus.i1_ra, rb: bus.i1_rb, rc: bus.i1_rc, rt: bus.i1_rt,
                 use_a: bus.i1_useA, use_b: bus.i1_useB, use_c: bus.i1_useC,
                 we: bus.i1_we, pipe: bus.i1_pipe, mem_read: bus.i1_memRead,
                 payload: bus.i1_payload};
  assign in2 = '{ra: bus.i2_ra, rb: bus.i2_rb, rc: bus.i2_rc, rt: bus.i2_rt,
                 use_a: bus.i2_useA, use_b: bus.i2_useB, use_c: bus.i2_useC,
                 we: bus.i2_we, pipe: bus.i2_pipe, mem_read: bus.i2_memRead,
                 payload: bus.i2_payload};

  assign bus.in_ready = reset & bus.out_ready & (state == EMPTY) & (bubble_cnt == 2'd0) & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // Issue candidates: held i2, a pair parked behind a bubble, or the pair on the inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    src1   = in1;
    src2   = in2;
    src2_v = bus.i2_valid;
    if (state == HOLD) begin
      src1   = hold_q;
      src2   = '0;
      src2_v = 1'b0;
    end else if (bubble_cnt != 2'd0) begin
      src1   = pend1_q;
      src2   = pend2_q;
      src2_v = pend2_v_q;
    end
  end

  // Hazard is only evaluated on a fresh candidate; a bubble already separates it from the load.
  assign fresh     = (bubble_cnt == 2'd0) & ((state == HOLD) | accept);
  assign drain     = (bubble_cnt == 2'd1);
  assign pair_conf = src2_v & conflict(src1, src2);
  assign hazard    = fresh & (load_dep(src1, s1_q, s2_q) |
                              (src2_v & ~pair_conf & load_dep(src2, s1_q, s2_q)));
  assign do_issue  = (fresh & ~hazard) | drain;

  always_comb begin
    s1_d = '0;
    s2_d = '0;
    if (do_issue) begin
      if (src1.pipe) s2_d = to_slot(src1);
      else           s1_d = to_slot(src1);
      if (src2_v & ~pair_conf) begin
        if (src2.pipe) s2_d = to_slot(src2);
        else           s1_d = to_slot(src2);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state      <= EMPTY;
      bubble_cnt <= 2'd0;
      hold_q     <= '0;
      pend1_q    <= '0;
      pend2_q    <= '0;
      pend2_v_q  <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else if (bus.flush) begin
      state      <= EMPTY;
      bubble_cnt <= 2'd0;
      hold_q     <= '0;
      pend1_q    <= '0;
      pend2_q    <= '0;
      pend2_v_q  <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else if (bus.out_ready) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      if (hazard) begin
        bubble_cnt <= BUBBLES;
        if (state == EMPTY) begin
          pend1_q   <= src1;
          pend2_q   <= src2;
          pend2_v_q <= src2_v;
        end
      end else if (bubble_cnt > 2'd1) begin
        bubble_cnt <= bubble_cnt - 2'd1;
      end else if (do_issue) begin
        bubble_cnt <= 2'd0;
        pend2_v_q  <= 1'b0;
        if (pair_conf) begin
          hold_q <= src2;
          state  <= HOLD;
        end else begin
          hold_q <= '0;
          state  <= EMPTY;
        end
      end
    end
  end

  assign bus.s1_valid   = s1_q.valid;
  assign bus.s1_ra      = s1_q.ra;
  assign bus.s1_rb      = s1_q.rb;
  assign bus.s1_rc      = s1_q.rc;
  assign bus.s1_rt      = s1_q.rt;
  assign bus.s1_we      = s1_q.we;
  assign bus.s1_memRead = s1_q.mem_read;
  assign bus.s1_payload = s1_q.payload;
  assign bus.s2_valid   = s2_q.valid;
  assign bus.s2_ra      = s2_q.ra;
  assign bus.s2_rb      = s2_q.rb;
  assign bus.s2_rc      = s2_q.rc;
  assign bus.s2_rt      = s2_q.rt;
  assign bus.s2_we      = s2_q.we;
  assign bus.s2_memRead = s2_q.mem_read;
  assign bus.s2_payload = s2_q.payload;

`ifdef ISSUE_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_dual   <= '0;
      perf_split  <= '0;
      perf_bubble <= '0;
    end else if (bus.out_ready & ~bus.flush) begin
      if (do_issue & src2_v & ~pair_conf) perf_dual   <= perf_dual + 32'd1;
      if (do_issue & pair_conf)           perf_split  <= perf_split + 32'd1;
      if (hazard | (bubble_cnt > 2'd1))   perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule
